conv_img_buf: RTL and testbench
===============================

// Module: conv_img_buf
// PURPOSE
//  Binary image line store that serves the 5x5 convolution engine's read interface.
//  Accepts one IMG_H x IMG_W binary frame as row words and pulses cal_start to launch the conv pass.
//  Answers each (row_cnt, data_rd_addr) read with a 5-bit column slice (rows row_cnt..row_cnt+4).
//  Stays busy until the engine finishes all N_CH kernels, then accepts the next frame.
// PARAMETERS
//  IMG_W  32  columns per row; equals the read-address span, so data_rd_addr runs 0..IMG_W-1
//  IMG_H  28  rows per frame; last conv row_cnt = IMG_H-K = 23
//  K      5   kernel height; col_data width
//  N_CH   30  kernel count; last conv_cnt = N_CH-1 = 29
//  AW     5   width of data_rd_addr / row_cnt / conv_cnt
// PORTS
//  clk           in   1      clock
//  rst_n         in   1      reset, asynchronous, active-low
//  clr           in   1      synchronous soft clear, 1-cycle pulse
//  in_row_data   in   IMG_W  one image row; bit c = pixel at column c
//  in_row_vld    in   1      in_row_data valid
//  in_row_rdy    out  1      buffer accepts a row; transfer occurs when vld & rdy
//  cal_start     out  1      1-cycle pulse: frame loaded, start convolution
//  data_rd_addr  in   AW     column read address from the conv engine
//  row_cnt       in   AW     top row of the current 5-row window
//  conv_cnt      in   AW     current kernel index
//  col_data      out  K      bit i = img[row_cnt+i][data_rd_addr]; registered
//  busy          out  1      high from cal_start until frame_done inclusive
//  frame_done    out  1      1-cycle pulse: conv pass over, buffer free
// BEHAVIOUR
//  Reset: in_row_rdy=0, cal_start=0, col_data=0, busy=0, frame_done=0; state=LOAD, wr_row=0; image array not reset.
//  FSM LOAD -> START -> CALC -> DONE -> LOAD.
//  LOAD: in_row_rdy=1 (from first cycle after reset release).
//   - On vld&rdy, in_row_data is written to img[wr_row]; wr_row increments.
//   - The write with wr_row==IMG_H-1 moves to START and wraps wr_row to 0.
//  START: rdy=0; cal_start=1 for exactly this one cycle; busy=1; next state CALC.
//   - cal_start rises the cycle after the last row handshake.
//  CALC: rdy=0, busy=1.
//   - End condition: conv_cnt==N_CH-1 && row_cnt==IMG_H-K && data_rd_addr==IMG_W-1, sampled at posedge; on match go to DONE.
//   - Read inputs are ignored in all other states.
//  DONE: frame_done=1, busy=1 for one cycle; next state LOAD (rdy=1 the cycle after).
//  Read port: col_data updates every cycle in every state.
//   - col_data[i] <= img[row_cnt+i][data_rd_addr]; latency exactly 1 clk.
//   - If row_cnt+i > IMG_H-1, bit i reads 0 (no wrap); compute row_cnt+i at AW+1 bits.
//   - Out-of-range data_rd_addr cannot occur since IMG_W=2^AW.
//  clr: any state -> LOAD next cycle; wr_row=0; cal_start/frame_done forced 0 that cycle; busy=0.
//   - clr with vld&rdy in the same cycle: clr wins, row discarded.
//  Reset mid-operation: state, counters and outputs return to reset values; the partial frame is discarded.
//  No write can alter the image during CALC (rdy=0), so reads within a frame are stable.
// STRUCTURE
//  Shared package cnn_pkg: IMG_W/IMG_H/K/N_CH/AW constants; state enum {LOAD,START,CALC,DONE}.
//  Image store: IMG_H x IMG_W flop array (896 bits); no RAM macro needed.
//  One natural sub-module: conv_col_slice: K parallel row muxes plus a bounds mask -> registered col_data.
//  FSM, wr_row counter and handshake stay in conv_img_buf.
// TESTING
//  1 Load rows r=0..27 with word 1<<r, vld held high
//    -> rdy drops after 28 accepts; cal_start exactly one cycle, the next cycle after the last accept; busy=1.
//  2 After load, drive row_cnt=3, data_rd_addr=5; row r=5 is 32'h20, others 0
//    -> col_data=5'b00100 one cycle later. Drive row_cnt=25, addr=0 with row 27 = 32'h1 -> col_data=5'b00100.
//    Rows 28/29 read as 0.
//  3 Checkerboard frame: sweep conv_cnt 0..29, row_cnt 0..23, addr 0..31 as the engine does
//    -> every col_data matches the model; frame_done pulses one cycle after (29,23,31); rdy=1 the following cycle.
//  4 (29,23,30) then (28,23,31) in CALC -> no frame_done; busy stays 1.
//  5 Backpressure: toggle vld randomly during LOAD
//    -> only vld&rdy cycles are stored; 2nd frame after DONE is loaded and served correctly.
//  6 clr at row 10 of LOAD, and again mid-CALC
//    -> wr_row=0, busy=0, no cal_start/frame_done. rst_n low mid-CALC -> all outputs 0, rdy=1 after release.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and types for the binary 5x5 convolution datapath.
package cnn_pkg;

  localparam int unsigned IMG_W = 32;
  localparam int unsigned IMG_H = 28;
  localparam int unsigned K     = 5;
  localparam int unsigned N_CH  = 30;
  localparam int unsigned AW    = 5;

  typedef enum logic [1:0] {
    LOAD,
    START,
    CALC,
    DONE
  } state_e;

  // Whole binary frame: [row][column]
  typedef logic [IMG_H-1:0][IMG_W-1:0] img_t;

endpackage

// File: rtl/conv_col_slice.sv
// K-row column slice of the image store; rows past the frame bottom read 0.
module conv_col_slice
  import cnn_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  img_t          img,
  input  logic [AW-1:0] row_cnt,
  input  logic [AW-1:0] rd_addr,
  output logic [K-1:0]  col_data
);

  logic [K-1:0] slice;

  // Row index is widened by one bit so row_cnt+i never wraps back into the frame
  for (genvar i = 0; i < K; i++) begin : g_row
    logic [AW:0] row_idx;
    assign row_idx  = {1'b0, row_cnt} + (AW+1)'(i);
    assign slice[i] = (row_idx < (AW+1)'(IMG_H)) ? img[row_idx[AW-1:0]][rd_addr] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_data <= '0;
    end else begin
      col_data <= slice;
    end
  end

endmodule

// File: rtl/conv_img_buf.sv
// Binary frame line store feeding the 5x5 conv engine: load rows, launch, serve column slices.
module conv_img_buf
  import cnn_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [IMG_W-1:0] in_row_data,
  input  logic             in_row_vld,
  output logic             in_row_rdy,
  output logic             cal_start,
  input  logic [AW-1:0]    data_rd_addr,
  input  logic [AW-1:0]    row_cnt,
  input  logic [AW-1:0]    conv_cnt,
  output logic [K-1:0]     col_data,
  output logic             busy,
  output logic             frame_done
);

  state_e        state_q;
  state_e        state_d;
  logic [AW-1:0] wr_row_q;
  logic [AW-1:0] wr_row_d;
  logic          wr_en;
  logic          calc_end;
  img_t          img_q;

  // clr wins over a simultaneous handshake, so the row is dropped
  assign wr_en    = in_row_vld & in_row_rdy & (state_q == LOAD) & ~clr;
  assign calc_end = (conv_cnt == AW'(N_CH-1)) && (row_cnt == AW'(IMG_H-K)) &&
                    (data_rd_addr == AW'(IMG_W-1));

  always_comb begin
    state_d  = state_q;
    wr_row_d = wr_row_q;
    case (state_q)
      LOAD: begin
        if (wr_en) begin
          if (wr_row_q == AW'(IMG_H-1)) begin
            state_d  = START;
            wr_row_d = '0;
          end else begin
            wr_row_d = wr_row_q + AW'(1);
          end
        end
      end
      START:   state_d = CALC;
      CALC:    if (calc_end) state_d = DONE;
      DONE:    state_d = LOAD;
      default: state_d = LOAD;
    endcase
    if (clr) begin
      state_d  = LOAD;
      wr_row_d = '0;
    end
  end

  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      wr_row_q   <= '0;
      in_row_rdy <= 1'b0;
      cal_start  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_row_q   <= wr_row_d;
      in_row_rdy <= (state_d == LOAD);
      cal_start  <= (state_d == START);
      busy       <= (state_d != LOAD);
      frame_done <= (state_d == DONE);
    end
  end

  // Image store is intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      img_q[wr_row_q] <= in_row_data;
    end
  end

  conv_col_slice u_col_slice (
    .clk      (clk),
    .rst_n    (rst_n),
    .img      (img_q),
    .row_cnt  (row_cnt),
    .rd_addr  (data_rd_addr),
    .col_data (col_data)
  );

endmodule

// File: tb/tb_conv_img_buf.sv
// Directed self-checking bench for conv_img_buf.
module tb_conv_img_buf;
  import cnn_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic [IMG_W-1:0] in_row_data = '0;
  logic             in_row_vld = 1'b0;
  logic             in_row_rdy;
  logic             cal_start;
  logic [AW-1:0]    data_rd_addr = '0;
  logic [AW-1:0]    row_cnt = '0;
  logic [AW-1:0]    conv_cnt = '0;
  logic [K-1:0]     col_data;
  logic             busy;
  logic             frame_done;

  int checks = 0;
  int errors = 0;
  logic [31:0] frame [28];

  conv_img_buf dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .in_row_data  (in_row_data),
    .in_row_vld   (in_row_vld),
    .in_row_rdy   (in_row_rdy),
    .cal_start    (cal_start),
    .data_rd_addr (data_rd_addr),
    .row_cnt      (row_cnt),
    .conv_cnt     (conv_cnt),
    .col_data     (col_data),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  function automatic logic [4:0] model_col(input int rc, input int ad);
    logic [4:0] v;
    v = '0;
    for (int i = 0; i < 5; i++) begin
      if (rc + i < 28) v[i] = frame[rc+i][ad];
    end
    return v;
  endfunction

  task automatic load_frame(input bit rand_vld, input int n_rows, output int cycles);
    int idx;
    bit acc;
    bit early;
    idx = 0;
    early = 1'b0;
    cycles = 0;
    while (idx < n_rows && cycles < 400) begin
      in_row_vld  = rand_vld ? 1'($urandom_range(0, 1)) : 1'b1;
      in_row_data = in_row_vld ? frame[idx] : 32'hDEAD_BEEF;
      acc = in_row_vld & in_row_rdy;
      if (cal_start) early = 1'b1;
      tick();
      cycles++;
      if (acc) idx++;
    end
    in_row_vld  = 1'b0;
    in_row_data = '0;
    checks++;
    if (idx != n_rows || early) begin
      errors++;
      $display("FAIL load_frame: accepted %0d rows early_start=%0b, expected %0d rows early_start=0",
               idx, early, n_rows);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({in_row_rdy, cal_start, busy, frame_done, col_data} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 000000000",
               {in_row_rdy, cal_start, busy, frame_done, col_data});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({in_row_rdy, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release_rdy: rdy,busy got %b, expected 10", {in_row_rdy, busy});
    end
  endtask

  task automatic test_load;
    int cyc;
    for (int r = 0; r < 28; r++) frame[r] = 32'h1 << r;
    load_frame(1'b0, 28, cyc);
    checks++;
    if (cyc !== 28) begin
      errors++;
      $display("FAIL load_cycles: got %0d, expected 28", cyc);
    end
    checks++;
    if ({in_row_rdy, cal_start, busy} !== 3'b011) begin
      errors++;
      $display("FAIL load_start: rdy,cal_start,busy got %b, expected 011", {in_row_rdy, cal_start, busy});
    end
    tick();
    checks++;
    if ({in_row_rdy, cal_start, busy} !== 3'b001) begin
      errors++;
      $display("FAIL start_one_cycle: rdy,cal_start,busy got %b, expected 001", {in_row_rdy, cal_start, busy});
    end
    row_cnt = 5'd0;
    data_rd_addr = 5'd0;
    tick();
    checks++;
    if (col_data !== 5'b00001) begin
      errors++;
      $display("FAIL diag_read: got %b, expected 00001", col_data);
    end
  endtask

  task automatic test_read;
    int cyc;
    logic [4:0] rc_t [6];
    logic [4:0] ad_t [6];
    logic [4:0] ex_t [6];
    rc_t = '{5'd3, 5'd25, 5'd27, 5'd25, 5'd1, 5'd5};
    ad_t = '{5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 5'd5};
    ex_t = '{5'b00100, 5'b00100, 5'b00001, 5'b00000, 5'b10000, 5'b00001};
    pulse_clr();
    for (int r = 0; r < 28; r++) frame[r] = '0;
    frame[5]  = 32'h20;
    frame[27] = 32'h1;
    load_frame(1'b0, 28, cyc);
    tick();
    for (int v = 0; v < 6; v++) begin
      row_cnt = rc_t[v];
      data_rd_addr = ad_t[v];
      tick();
      checks++;
      if (col_data !== ex_t[v]) begin
        errors++;
        $display("FAIL read_%0d row_cnt=%0d addr=%0d: got %b, expected %b",
                 v, rc_t[v], ad_t[v], col_data, ex_t[v]);
      end
    end
  endtask

  task automatic test_end_cond;
    int cyc;
    pulse_clr();
    for (int r = 0; r < 28; r++) frame[r] = r[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
    load_frame(1'b0, 28, cyc);
    tick();
    conv_cnt = 5'd29; row_cnt = 5'd23; data_rd_addr = 5'd30;
    tick();
    checks++;
    if ({frame_done, busy} !== 2'b01) begin
      errors++;
      $display("FAIL near_end_addr: frame_done,busy got %b, expected 01", {frame_done, busy});
    end
    conv_cnt = 5'd28; row_cnt = 5'd23; data_rd_addr = 5'd31;
    tick();
    checks++;
    if ({frame_done, busy} !== 2'b01) begin
      errors++;
      $display("FAIL near_end_conv: frame_done,busy got %b, expected 01", {frame_done, busy});
    end
    checks++;
    if (col_data !== 5'b01010) begin
      errors++;
      $display("FAIL checker_read: got %b, expected 01010", col_data);
    end
  endtask

  task automatic test_sweep;
    int bad;
    bit last;
    logic [4:0] exp_col;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      for (int rc = 0; rc < 24; rc++) begin
        for (int ad = 0; ad < 32; ad++) begin
          conv_cnt = 5'(c); row_cnt = 5'(rc); data_rd_addr = 5'(ad);
          last = (c == 29 && rc == 23 && ad == 31);
          exp_col = model_col(rc, ad);
          tick();
          if (col_data !== exp_col || frame_done !== last || busy !== 1'b1) bad++;
        end
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sweep: %0d bad cycles, expected 0", bad);
    end
    conv_cnt = '0; row_cnt = '0; data_rd_addr = '0;
    tick();
    checks++;
    if ({in_row_rdy, busy, frame_done} !== 3'b100) begin
      errors++;
      $display("FAIL after_done: rdy,busy,frame_done got %b, expected 100", {in_row_rdy, busy, frame_done});
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    int bad;
    logic [4:0] exp_col;
    for (int r = 0; r < 28; r++) frame[r] = 32'h9E37_79B9 * 32'(r + 1);
    load_frame(1'b1, 28, cyc);
    checks++;
    if ({in_row_rdy, cal_start, busy} !== 3'b011) begin
      errors++;
      $display("FAIL bp_start: rdy,cal_start,busy got %b, expected 011", {in_row_rdy, cal_start, busy});
    end
    tick();
    bad = 0;
    for (int rc = 0; rc < 28; rc++) begin
      for (int ad = 0; ad < 32; ad++) begin
        row_cnt = 5'(rc); data_rd_addr = 5'(ad);
        exp_col = model_col(rc, ad);
        tick();
        if (col_data !== exp_col) bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_contents: %0d bad reads, expected 0", bad);
    end
  endtask

  task automatic test_clr;
    int cyc;
    pulse_clr();
    checks++;
    if ({in_row_rdy, cal_start, busy, frame_done} !== 4'b1000) begin
      errors++;
      $display("FAIL clr_calc: rdy,cal_start,busy,frame_done got %b, expected 1000",
               {in_row_rdy, cal_start, busy, frame_done});
    end
    for (int r = 0; r < 28; r++) frame[r] = ~(32'h1 << r);
    load_frame(1'b0, 10, cyc);
    clr = 1'b1; in_row_vld = 1'b1; in_row_data = frame[10];
    tick();
    clr = 1'b0; in_row_vld = 1'b0;
    checks++;
    if ({in_row_rdy, cal_start, busy} !== 3'b100) begin
      errors++;
      $display("FAIL clr_load: rdy,cal_start,busy got %b, expected 100", {in_row_rdy, cal_start, busy});
    end
    load_frame(1'b0, 28, cyc);
    checks++;
    if (cyc !== 28 || cal_start !== 1'b1) begin
      errors++;
      $display("FAIL clr_reload: cycles=%0d cal_start=%b, expected 28 and 1", cyc, cal_start);
    end
    tick();
    row_cnt = 5'd0; data_rd_addr = 5'd0;
    tick();
    checks++;
    if (col_data !== 5'b11110) begin
      errors++;
      $display("FAIL clr_read0: got %b, expected 11110", col_data);
    end
    row_cnt = 5'd8; data_rd_addr = 5'd10;
    tick();
    checks++;
    if (col_data !== 5'b11011) begin
      errors++;
      $display("FAIL clr_read8: got %b, expected 11011", col_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_row_rdy, cal_start, busy, frame_done, col_data} !== 9'b0) begin
      errors++;
      $display("FAIL mid_reset: got %b, expected 000000000",
               {in_row_rdy, cal_start, busy, frame_done, col_data});
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({in_row_rdy, busy} !== 2'b10) begin
      errors++;
      $display("FAIL mid_reset_release: rdy,busy got %b, expected 10", {in_row_rdy, busy});
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_read();
    test_end_cond();
    test_sweep();
    test_back_to_back();
    test_clr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
